// File: rtl/debug_pkg.sv
// Shared constants and types for the debug mailbox: function codes written to
// word 0 and the PRINT unpacker state encoding.
package debug_pkg;

    localparam logic [31:0] DBG_FINISH    = 32'h0000_0000;
    localparam logic [31:0] DBG_ASSERT_EQ = 32'h0000_0001;
    localparam logic [31:0] DBG_ASSERT_NE = 32'h0000_0002;
    localparam logic [31:0] DBG_PRINT     = 32'h0000_0003;
    localparam logic [31:0] DBG_REGCHK    = 32'h0001_0000;
    localparam logic [31:0] DBG_DUMP      = 32'hFFFF_0000;

    typedef enum logic {
        IDLE,
        UNPACK
    } unpack_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous circular FIFO of bytes with full/empty flags and an occupancy count.
// The head reads as zero while empty so the consumer never sees stale storage.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = count_q[AW];
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/debug_mailbox.sv
// Memory-mapped debug mailbox: argument words, word-0 command strobe, sticky
// FINISH/overflow flags, and a PRINT unpacker feeding a console byte FIFO.
module debug_mailbox
    import debug_pkg::*;
#(
    parameter int ARG_WORDS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              we,
    input  logic [$clog2(ARG_WORDS)-1:0]      addr,
    input  logic [31:0]                       wd,
    output logic [31:0]                       rd,
    output logic [ARG_WORDS-1:0][31:0]        datas,
    output logic                              cmd_valid,
    output logic [31:0]                       cmd_func,
    output logic                              busy,
    output logic                              char_valid,
    output logic [7:0]                        char_data,
    input  logic                              char_ready,
    output logic                              halted,
    output logic                              overflow
);

    logic [ARG_WORDS-1:0][31:0] datas_q;
    logic                       cmd_valid_q;
    logic [31:0]                cmd_func_q;
    logic                       halted_q;
    logic                       overflow_q;
    logic [31:0]                snap_q;
    unpack_state_e              state_q, state_d;
    logic [1:0]                 idx_q, idx_d;

    logic                       word0_wr, print_wr;
    logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                 cur_byte, fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign word0_wr = we && (addr == '0);
    assign print_wr = word0_wr && (wd == DBG_PRINT);
    assign cur_byte = snap_q[{idx_q, 3'b000} +: 8];
    assign fifo_pop = !fifo_empty && char_ready;

    assign rd         = datas_q[addr];
    assign datas      = datas_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_func   = cmd_func_q;
    assign halted     = halted_q;
    assign overflow   = overflow_q;
    assign char_valid = !fifo_empty;
    assign char_data  = fifo_head;
    // Count MSB is set exactly when the FIFO holds FIFO_DEPTH bytes.
    assign busy       = (state_q != IDLE) || fifo_count[$clog2(FIFO_DEPTH)];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (print_wr) begin
                    state_d = UNPACK;
                    idx_d   = 2'd0;
                end
            end
            UNPACK: begin
                // A NUL terminates the string without being pushed.
                if (cur_byte == 8'h00) begin
                    state_d = IDLE;
                end else if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    if (idx_q == 2'd3) state_d = IDLE;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            datas_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_func_q  <= '0;
            halted_q    <= 1'b0;
            overflow_q  <= 1'b0;
            snap_q      <= '0;
            state_q     <= IDLE;
            idx_q       <= 2'd0;
        end else begin
            if (we) datas_q[addr] <= wd;
            cmd_valid_q <= word0_wr;
            if (word0_wr) cmd_func_q <= wd;
            if (word0_wr && (wd == DBG_FINISH)) halted_q <= 1'b1;
            // A PRINT arriving mid-string is dropped; the current string carries on.
            if (print_wr && (state_q == UNPACK)) overflow_q <= 1'b1;
            if (print_wr && (state_q == IDLE))   snap_q     <= datas_q[1];
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (cur_byte),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_debug_mailbox.sv
// Self-checking bench for debug_mailbox: table-driven word/strobe vectors plus
// hand-written PRINT, backpressure, overflow and mid-string reset sequences.
module tb_debug_mailbox;

    logic             clk;
    logic             reset;
    logic             we;
    logic [2:0]       addr;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic [7:0][31:0] datas;
    logic             cmd_valid;
    logic [31:0]      cmd_func;
    logic             busy;
    logic             char_valid;
    logic [7:0]       char_data;
    logic             char_ready;
    logic             halted;
    logic             overflow;

    int passed = 0;
    int total  = 0;
    logic [7:0] got_q [$];

    debug_mailbox #(.ARG_WORDS(8), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd),
        .datas      (datas),
        .cmd_valid  (cmd_valid),
        .cmd_func   (cmd_func),
        .busy       (busy),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .halted     (halted),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Console sink model: records every byte that the handshake accepts.
    always @(negedge clk) begin
        if (reset && char_valid && char_ready) got_q.push_back(char_data);
    end

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_cv;
        logic [31:0] exp_func;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             passed++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_datas"},     32'(datas == '0), 32'd1);
        chk({tag, "_cmd_func"},  cmd_func,   32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid),  32'd0);
        chk({tag, "_char_valid"},32'(char_valid), 32'd0);
        chk({tag, "_char_data"}, 32'(char_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),       32'd0);
        chk({tag, "_halted"},    32'(halted),     32'd0);
        chk({tag, "_overflow"},  32'(overflow),   32'd0);
    endtask

    function automatic logic [31:0] str_word(input int p);
        logic [7:0] b;
        b = 8'h41 + 8'(4 * p);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        bit ok;
        bit saw;
        logic [7:0] hello [4];

        we = 1'b0; addr = '0; wd = '0; char_ready = 1'b0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1 chk_reset_state("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Word writes, same-cycle read-old, strobe for every function code.
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b0, 3'd2, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 3'd5, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 3'd0, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0001_0000};
        vecs[6]  = '{1'b1, 3'd0, 32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'hFFFF_0000};
        vecs[7]  = '{1'b0, 3'd5, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'hFFFF_0000};
        vecs[8]  = '{1'b1, 3'd7, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 32'hFFFF_0000};
        vecs[9]  = '{1'b0, 3'd7, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'hFFFF_0000};
        vecs[10] = '{1'b1, 3'd0, 32'h0000_0002, 32'hFFFF_0000, 1'b1, 32'h0000_0002};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0001};

        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            we   = vecs[i].we;
            addr = vecs[i].addr;
            wd   = vecs[i].wd;
            #1 chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            we = 1'b0;
            chk($sformatf("vec%0d_cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_cv));
            chk($sformatf("vec%0d_cmd_func", i), cmd_func, vecs[i].exp_func);
            if (i == 1) chk("finish_halted", 32'(halted), 32'd1);
        end
        chk("halted_sticky", 32'(halted), 32'd1);
        chk("datas2", datas[2], 32'h0000_0001);
        chk("datas5", datas[5], 32'h1234_5678);
        chk("datas7", datas[7], 32'hA5A5_A5A5);

        // Second PRINT while the first is still unpacking is dropped.
        char_ready = 1'b1;
        got_q.delete();
        wr(3'd1, 32'h4443_4241);
        wr(3'd0, 32'd3);
        wr(3'd1, 32'h5A59_5857);
        wr(3'd0, 32'd3);
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (12) @(negedge clk);
        chk("ovf_count", got_q.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < got_q.size()) chk($sformatf("ovf_byte%0d", k), 32'(got_q[k]), 32'(8'h41 + 8'(k)));
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_idle", 32'(busy), 32'd0);

        // Asynchronous reset with a partial string: 3 bytes queued, unpacker mid-word.
        char_ready = 1'b0;
        got_q.delete();
        wr(3'd1, 32'h4443_4241);
        wr(3'd0, 32'd3);
        repeat (4) @(negedge clk);
        chk("mid_count", 32'(dut.u_fifo.count_q), 32'd3);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_head", 32'(char_data), 32'h41);
        reset = 1'b0;
        #1 chk_reset_state("mid_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        char_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (char_valid) saw = 1'b1;
        end
        chk("post_rst_no_valid", 32'(saw), 32'd0);
        chk("post_rst_no_bytes", got_q.size(), 32'd0);

        // "Hell": four bytes on consecutive cycles from N+2, busy low from N+5.
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C;
        @(posedge clk);
        #1;
        wr(3'd1, 32'h6C6C_6548);
        wr(3'd0, 32'd3);
        @(negedge clk);
        chk("hell_n1_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("hell_n1_busy", 32'(busy), 32'd1);
        chk("hell_n1_char_valid", 32'(char_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hell_n%0d_valid", k + 2), 32'(char_valid), 32'd1);
            chk($sformatf("hell_n%0d_data", k + 2), 32'(char_data), 32'(hello[k]));
            chk($sformatf("hell_n%0d_busy", k + 2), 32'(busy), (k < 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("hell_n6_valid", 32'(char_valid), 32'd0);
        chk("hell_n6_busy", 32'(busy), 32'd0);

        // NUL-terminated "HI": two bytes then idle.
        @(posedge clk);
        #1;
        wr(3'd1, 32'h0000_4948);
        wr(3'd0, 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("hi_n2_data", 32'(char_data), 32'h48);
        chk("hi_n2_valid", 32'(char_valid), 32'd1);
        @(negedge clk);
        chk("hi_n3_data", 32'(char_data), 32'h49);
        chk("hi_n3_valid", 32'(char_valid), 32'd1);
        @(negedge clk);
        chk("hi_n4_valid", 32'(char_valid), 32'd0);
        chk("hi_n4_busy", 32'(busy), 32'd0);

        // Backpressure: four PRINTs fill the FIFO, the fifth waits on busy.
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wait_not_busy(ok);
            chk($sformatf("bp_wait%0d", p), 32'(ok), 32'd1);
            wr(3'd1, str_word(p));
            wr(3'd0, 32'd3);
        end
        repeat (10) @(negedge clk);
        chk("bp_full_busy", 32'(busy), 32'd1);
        chk("bp_full_count", 32'(dut.u_fifo.count_q), 32'd16);
        chk("bp_full_head", 32'(char_data), 32'h41);
        chk("bp_full_ovf", 32'(overflow), 32'd0);
        got_q.delete();
        @(posedge clk);
        #1;
        char_ready = 1'b1;
        wait_not_busy(ok);
        chk("bp_wait4", 32'(ok), 32'd1);
        wr(3'd1, str_word(4));
        wr(3'd0, 32'd3);
        for (int c = 0; c < 200 && got_q.size() < 20; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("bp_drain_count", got_q.size(), 32'd20);
        for (int k = 0; k < 20; k++)
            if (k < got_q.size()) chk($sformatf("bp_byte%0d", k), 32'(got_q[k]), 32'(8'h41 + 8'(k)));
        chk("bp_ovf", 32'(overflow), 32'd0);
        chk("bp_empty", 32'(char_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
